// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding, default PC
// constants and the word-alignment check.
package fetch_unit_pkg;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } fetch_state_e;

  localparam int          PC_INC_DEFAULT   = 4;
  localparam int          RESET_PC_DEFAULT = 0;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;

  function automatic logic word_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with sequential incrementer and branch-redirect mux.
// The PC only moves when the fetch unit commits a write-back.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                PC_INC   = PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Wraps modulo 2^ADDR_W by truncation.
  assign pc_plus = pc_q + ADDR_W'(PC_INC);
  assign next_pc = branch_taken ? branch_target : pc_plus;
  assign pc      = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (commit) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch unit: issues one word read per IF/WB stage strobe, holds
// the IR, and stalls the stage controller while a read is outstanding.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                PC_INC   = PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stateIF,
  input  logic              stateWB,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic [DATA_W-1:0] ir,
  output logic              instr_valid,
  output logic              fetch_busy,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_err_q, fetch_err_d;

  logic              trigger;
  logic              commit;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic              misaligned;

  fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .commit        (commit),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .next_pc       (next_pc)
  );

  // WB wins over IF when both strobes arrive together.
  assign trigger    = (state_q == F_IDLE) & (stateIF | stateWB) & ~fetch_err_q;
  assign commit     = trigger & stateWB;
  assign fetch_addr = stateWB ? next_pc : pc;
  assign misaligned = word_misaligned(fetch_addr[1:0]);

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    ir_d          = ir_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    case (state_q)
      F_IDLE: begin
        if (trigger) begin
          instr_valid_d = 1'b0;
          req_addr_d    = fetch_addr;
          if (misaligned) begin
            fetch_err_d = 1'b1;
          end else begin
            state_d = F_WAIT;
          end
        end
      end
      F_WAIT: begin
        if (imem_valid) begin
          ir_d          = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = F_IDLE;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= F_IDLE;
      req_addr_q    <= '0;
      ir_q          <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // Busy drops on the cycle the data returns so the controller advances on the IR-load edge.
  assign fetch_busy  = trigger | ((state_q == F_WAIT) & ~imem_valid);
  assign imem_req    = (state_q == F_WAIT);
  assign imem_addr   = req_addr_q;
  assign ir          = ir_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// strobes, checked every cycle against a transaction-level fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stateIF, stateWB, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc, pc_plus, ir;
  logic        instr_valid, fetch_busy, fetch_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural view of the fetch unit.
  logic [31:0] m_pc, m_ir, m_addr;
  logic        m_valid, m_err, m_pending;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stateIF       (stateIF),
    .stateWB       (stateWB),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .ir            (ir),
    .instr_valid   (instr_valid),
    .fetch_busy    (fetch_busy),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive inputs after the falling edge, check outputs, advance the model.
  task automatic cycle(input logic rst, input logic s_if, input logic s_wb, input logic bt,
                       input logic [31:0] tgt, input logic vld, input logic [31:0] rdata);
    logic        trig, exp_busy;
    logic [31:0] faddr;
    @(negedge clk);
    reset = rst; stateIF = s_if; stateWB = s_wb; branch_taken = bt;
    branch_target = tgt; imem_valid = vld; imem_rdata = rdata;
    #1;
    trig     = !m_pending && (s_if || s_wb) && !m_err;
    exp_busy = trig || (m_pending && !vld);
    check("pc", pc, m_pc);
    check("pc_plus", pc_plus, m_pc + 32'd4);
    check("ir", ir, m_ir);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    check("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    check("imem_req", {31'b0, imem_req}, {31'b0, m_pending});
    check("fetch_busy", {31'b0, fetch_busy}, {31'b0, exp_busy});
    if (m_pending) check("imem_addr", imem_addr, m_addr);
    $display("cyc rst=%0b if=%0b wb=%0b bt=%0b tgt=%h vld=%0b | pc=%h req=%0b addr=%h busy=%0b ir=%h iv=%0b err=%0b",
             rst, s_if, s_wb, bt, tgt, vld, pc, imem_req, imem_addr, fetch_busy, ir, instr_valid, fetch_err);
    if (rst) begin
      m_pc = 32'h0; m_ir = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_pending = 1'b0;
    end else if (m_pending) begin
      if (vld) begin
        m_ir = rdata; m_valid = 1'b1; m_pending = 1'b0;
      end
    end else if (trig) begin
      faddr = s_wb ? (bt ? tgt : m_pc + 32'd4) : m_pc;
      if (s_wb) m_pc = faddr;
      m_valid = 1'b0;
      if (faddr % 4 != 0) m_err = 1'b1;
      else begin
        m_pending = 1'b1; m_addr = faddr;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    m_pc = 32'h0; m_ir = 32'h0; m_addr = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_pending = 1'b0;
    reset = 1'b1; stateIF = 1'b0; stateWB = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_valid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);

    // IF fetch at reset PC, zero-wait memory.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00A00093);
    idle(1);

    // Sequential WBs up to pc=0x10, then 0x14 with three wait states.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000 + k);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    idle(1);

    // Taken branch to 0x100, with IF also high to exercise WB priority.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678);
    idle(1);

    // Misaligned branch sets the sticky error; later strobes do nothing.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h102, 1'b0, 32'h0);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55555555);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);

    // Reset in the middle of a fetch; the late data must be dropped.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D);
    idle(1);

    // PC wrap from 0xFFFFFFFC to 0.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA0001);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA0002);
    idle(1);

    // Random strobes, branches, wait states and occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic        r_rst, r_if, r_wb, r_bt, r_vld;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 39) == 0) || (m_err && $urandom_range(0, 3) == 0);
      r_if  = ($urandom_range(0, 2) == 0);
      r_wb  = ($urandom_range(0, 2) == 0);
      r_bt  = $urandom_range(0, 1);
      r_tgt = $urandom & ~32'h3;
      if ($urandom_range(0, 15) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
      r_vld = ($urandom_range(0, 2) == 0);
      cycle(r_rst, r_if, r_wb, r_bt, r_tgt, r_vld, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
